// File: rtl/fp_pkg.sv
// fp_pkg: shared float32 <-> half constants, pack FSM states and byte-lane helper.
package fp_pkg;
    localparam int F16_BIAS_OFFSET = 112;
    localparam int F16_EXP_MAX_F32 = 143;
    localparam logic [14:0] F16_CLAMP_MAG = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, HAVE_HI, OUT} pack_state_t;

    function automatic logic [15:0] lane_swap(input logic [15:0] h);
        return {h[7:0], h[15:8]};
    endfunction
endpackage

// File: rtl/f32_to_f16_conv.sv
// f32_to_f16_conv: float32 to half narrowing, truncating mantissa, flushing small values to zero and clamping large ones.
module f32_to_f16_conv
    import fp_pkg::*;
(
    input  logic [31:0] f32,
    output logic [15:0] half,
    output logic        sat
);
    logic [7:0] e;
    logic [4:0] e_adj;
    logic       unused_lsbs;

    assign e = f32[30:23];
    assign e_adj = 5'(e - 8'(F16_BIAS_OFFSET));
    // Truncation discards the low mantissa bits.
    assign unused_lsbs = &{1'b0, f32[12:0]};

    always_comb begin
        sat = e > 8'(F16_EXP_MAX_F32);
        half = sat ? {f32[31], F16_CLAMP_MAG} :
               (e < 8'(F16_BIAS_OFFSET)) ? {f32[31], 15'h0000} :
               {f32[31], e_adj, f32[22:13]};
    end
endmodule

// File: rtl/f32_to_f16_pack.sv
// f32_to_f16_pack: streams float32 beats in, emits two byte-swapped halves per 32-bit word.
module f32_to_f16_pack
    import fp_pkg::*;
#(
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic                 m_last,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
);
    pack_state_t state, state_nxt;
    logic [15:0] hi_q, hi_nxt, half;
    logic [31:0] data_nxt;
    logic        last_nxt, sat, xfer;

    f32_to_f16_conv u_conv (
        .f32  (s_data),
        .half (half),
        .sat  (sat)
    );

    assign s_ready = (state != OUT) || m_ready;
    assign xfer    = s_valid && s_ready;
    assign m_valid = state == OUT;

    // A retiring word behaves like IDLE, so a new element is taken without a bubble.
    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_q;
        data_nxt  = m_data;
        last_nxt  = m_last;
        if (state == OUT && m_ready)
            state_nxt = IDLE;
        if (xfer) begin
            if (state == HAVE_HI) begin
                state_nxt = OUT;
                data_nxt  = {lane_swap(hi_q), lane_swap(half)};
                last_nxt  = s_last;
            end else if (s_last) begin
                state_nxt = OUT;
                data_nxt  = {lane_swap(half), 16'h0000};
                last_nxt  = 1'b1;
            end else begin
                state_nxt = HAVE_HI;
                hi_nxt    = half;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi_q      <= '0;
            m_data    <= '0;
            m_last    <= 1'b0;
            sat_count <= '0;
        end else begin
            state     <= state_nxt;
            hi_q      <= hi_nxt;
            m_data    <= data_nxt;
            m_last    <= last_nxt;
            sat_count <= sat_clr ? '0 :
                         (xfer && sat && !(&sat_count)) ? sat_count + SAT_CNT_W'(1) : sat_count;
        end
    end
endmodule

// File: tb/tb_f32_to_f16_pack.sv
// tb_f32_to_f16_pack: directed vector table, corner sequences and randomized handshake against a scoreboard model.
module tb_f32_to_f16_pack;
    logic        clk = 1'b0;
    logic        rst_n, s_valid, s_ready, s_last, m_valid, m_ready, m_last, sat_clr;
    logic [31:0] s_data, m_data;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    logic [32:0] q[$];
    logic        have, hold_prev;
    logic [15:0] mhi, msat;
    logic [31:0] prev_data;

    typedef struct {
        logic [31:0] a, b;
        logic        single, last, clr;
        logic [31:0] w;
        logic [15:0] sat;
    } vec_t;
    vec_t vecs[7];

    f32_to_f16_pack #(.SAT_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_half(input logic [31:0] x);
        int e;
        e = int'(x[30:23]);
        if (e < 112) return {x[31], 15'h0000};
        if (e > 143) return {x[31], 15'h7FFF};
        return {x[31], 5'(e - 112), x[22:13]};
    endfunction

    function automatic logic [15:0] swap16(input logic [15:0] h);
        return {h[7:0], h[15:8]};
    endfunction

    function automatic logic [31:0] unpack(input logic [15:0] h);
        return {h[15], 8'(h[14:10] + 8'd112), h[9:0], 13'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic sample();
        logic [32:0] e;
        logic [15:0] h;
        logic        cl;
        if (!rst_n) begin
            q.delete();
            have = 1'b0;
            msat = '0;
            hold_prev = 1'b0;
            return;
        end
        chk("sat_count", 32'(sat_count), 32'(msat));
        if (m_valid && !m_ready) begin
            if (hold_prev) chk("hold_data", m_data, prev_data);
            hold_prev = 1'b1;
            prev_data = m_data;
        end else
            hold_prev = 1'b0;
        if (m_valid && m_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got %h want none", m_data);
            end else begin
                e = q.pop_front();
                chk("sb_data", m_data, e[31:0]);
                chk("sb_last", 32'(m_last), 32'(e[32]));
            end
        end
        if (s_valid && s_ready) begin
            h  = ref_half(s_data);
            cl = s_data[30:23] > 8'd143;
            if (have) begin
                q.push_back({s_last, swap16(mhi), swap16(h)});
                have = 1'b0;
            end else if (s_last)
                q.push_back({1'b1, swap16(h), 16'h0000});
            else begin
                have = 1'b1;
                mhi  = h;
            end
            msat = sat_clr ? 16'h0 : (cl && msat != 16'hFFFF) ? msat + 16'h1 : msat;
        end else if (sat_clr)
            msat = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        logic acc;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = s_ready;
            sample();
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1; sat_clr = 1'b0;
        have = 1'b0; hold_prev = 1'b0; mhi = '0; msat = '0; prev_data = '0;
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 32'h003C0040, 16'd0};
        vecs[1] = '{32'h40490FDB, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h48420000, 16'd0};
        vecs[2] = '{32'h49742400, 32'hFF800000, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 16'd2};
        vecs[3] = '{32'h2EDBE6FF, 32'hBF000000, 1'b0, 1'b0, 1'b1, 32'h000000B8, 16'd0};
        vecs[4] = '{32'h38400000, 32'h477FE000, 1'b0, 1'b0, 1'b0, 32'h0002FF7B, 16'd0};
        vecs[5] = '{32'h47800000, 32'h37FFFFFF, 1'b0, 1'b0, 1'b0, 32'h007C0000, 16'd0};
        vecs[6] = '{32'h3F800000, 32'hC0000000, 1'b0, 1'b1, 1'b0, 32'h003C00C0, 16'd0};
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_sat", 32'(sat_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("idle_s_ready", 32'(s_ready), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].clr) begin
                sat_clr = 1'b1;
                tick();
                sat_clr = 1'b0;
                chk("sat_clr", 32'(sat_count), 32'd0);
            end
            if (vecs[i].single)
                push(vecs[i].a, 1'b1);
            else begin
                push(vecs[i].a, 1'b0);
                chk("mid_pair_m_valid", 32'(m_valid), 32'd0);
                push(vecs[i].b, vecs[i].last);
            end
            chk("vec_m_valid", 32'(m_valid), 32'd1);
            chk("vec_m_data", m_data, vecs[i].w);
            chk("vec_m_last", 32'(m_last), 32'(vecs[i].last));
            chk("vec_sat", 32'(sat_count), 32'(vecs[i].sat));
            tick();
        end

        push(32'h40490FDB, 1'b1);
        chk("unpack_roundtrip", unpack(swap16(m_data[31:16])), 32'h40490000);
        tick();

        m_ready = 1'b0;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h40490FDB;
        s_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", m_data, 32'h003C0040);
        end
        m_ready = 1'b1;
        push(32'h40490FDB, 1'b0);
        push(32'h3F800000, 1'b1);
        chk("bp_next_word", m_data, 32'h4842003C);
        chk("bp_next_last", 32'(m_last), 32'd1);
        tick();

        push(32'h3F800000, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_hi_m_valid", 32'(m_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b0);
        chk("rst_stale_word", m_data, 32'h00400040);
        tick();

        m_ready = 1'b0;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        chk("out_m_valid", 32'(m_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_out_m_valid", 32'(m_valid), 32'd0);
        chk("rst_out_m_data", m_data, 32'h0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;

        sat_clr = 1'b1;
        push(32'hFF800000, 1'b0);
        sat_clr = 1'b0;
        chk("clr_wins", 32'(sat_count), 32'd0);
        push(32'h7F800000, 1'b1);
        chk("inf_word", m_data, 32'hFFFFFF7F);
        chk("inf_sat", 32'(sat_count), 32'd1);
        tick();

        for (int i = 0; i < 1000; i++) begin
            logic acc;
            int n;
            s_data = $urandom();
            s_last = $urandom_range(0, 7) == 0;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                s_valid = $urandom_range(0, 3) != 0;
                m_ready = $urandom_range(0, 3) != 0;
                @(negedge clk);
                acc = s_valid && s_ready;
                sample();
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) chk("rand_timeout", 32'(acc), 32'd1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
